qpsk_mseq_mod: RTL and testbench
================================

# qpsk_mseq_mod

Self-contained QPSK baseband modulator test source. A 5-bit maximal-length LFSR produces a 31-bit-period m-sequence. The sequence is paired into dibits and mapped to ±127 I/Q levels. The I/Q levels are then mixed onto an fs/4 digital carrier, giving 8-bit samples for a downstream DAC or simulation display. It sits at the top of the m-function demo, driven directly by the board 50 MHz clock.

## Interface
- No parameters. All constants are fixed in the package.
- CLK_50MHZ  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- out_fun  out  1  current m-sequence bit (LFSR bit 0).
- dataI  out  8  signed in-phase level: 8'h7F (+127), 8'h81 (−127), or 0 after reset.
- dataQ  out  8  signed quadrature level, same encoding as dataI.
- data_origin  out  8  signed modulated carrier sample.
- buff_wr  out  31  history of the last 31 emitted bits, newest in bit 0.

## Operation
- Phase counter ph[1:0] increments every clock and wraps 3→0.
- Advance event: an edge where ph (pre-edge value) is 1 or 3.
- LFSR lfsr[4:0]:
  - Fibonacci, right-shift, polynomial x^5+x^3+1.
  - Next state = {lfsr[0]^lfsr[3], lfsr[4:1]}; updates only on advance events.
  - out_fun = lfsr[0], combinational from the register.
- buff_wr: on each advance event, buff_wr ← {buff_wr[29:0], lfsr[0]}.
- Dibit assembly:
  - At the ph==1 advance, lfsr[0] is latched as bit b1.
  - At the ph==3 advance, the symbol {b1, b2 = lfsr[0]} is formed and dataI/dataQ are updated.
- Mapping (default): I = b1 ? −127 : +127; Q = b2 ? −127 : +127.
- Carrier mixing: every clock, data_origin ← sel(ph) on the current dataI/dataQ registers:
  - ph 0 → I
  - ph 1 → −Q
  - ph 2 → −I
  - ph 3 → Q
- Arithmetic: two's-complement 8-bit. Negating ±127 and 0 never overflows. No −128 value is ever produced.
- The LFSR never reaches all-zero from the reset seed, so no lock-up recovery is needed.

## Timing
- Reset values:
  - lfsr = 5'b00001, so out_fun = 1.
  - ph = 0, b1 = 0, buff_wr = 0.
  - dataI = dataQ = data_origin = 0.
- Bit period: 2 clocks. Symbol period: 4 clocks, which is one carrier cycle.
- Sequence period: 31 bits = 62 clocks. The bit stream repeats exactly every 62 clocks.
- First symbol appears on dataI/dataQ after the 4th rising edge following reset release.
- data_origin lags dataI/dataQ by one register stage.
- Reset asserted mid-symbol immediately clears all state. The partial dibit is discarded and the sequence restarts from the seed.

## Configuration
- QPSK_DIFF_EN defined: differential encoding.
  - A 2-bit quadrant register q (reset 0) is kept.
  - Gray increment d = {b1,b2}: 00→0, 01→1, 11→2, 10→3.
  - q ← q + d mod 4 at each symbol.
  - Quadrant to levels: 0:(+127,+127), 1:(−127,+127), 2:(−127,−127), 3:(+127,−127).
- QPSK_DIFF_EN undefined: direct mapping as in Operation; no q register exists.

## Structure
- Package qpsk_pkg holds:
  - AMP_POS = 8'sh7F, AMP_NEG = 8'sh81
  - LFSR_SEED = 5'b00001
  - LFSR_W = 5, SEQ_LEN = 31
  - the ph-to-carrier-sign constants
- One sub-module, mseq_lfsr, containing:
  - inputs: clk, rst_n, en
  - outputs: bit_o, state
- The top instantiates mseq_lfsr and holds the phase counter, dibit latch, mapper, mixer and buff_wr.

## Test plan
- Reset: hold RST_N low, then check out_fun = 1, buff_wr = 0, and dataI = dataQ = data_origin = 0.
- Sequence: after release, sample out_fun at every advance event. Expect 1,0,0,0,0,1,… (first six bits), with exact repetition after 31 bits (62 clocks). Each 31-bit window contains 16 ones.
- Mapping, default build:
  - after edge 4, dataI = 8'h81 and dataQ = 8'h7F (dibit 10);
  - after edge 8, dataI = dataQ = 8'h7F (dibit 00);
  - after edge 12, dataI = 8'h7F and dataQ = 8'h81 (dibit 01).
- Carrier: over one steady symbol with I = 8'h81 and Q = 8'h7F, data_origin cycles 8'h81, 8'h81, 8'h7F, 8'h7F on consecutive ph 0..3.
- History: after 62 clocks, buff_wr equals the 31 emitted bits in order, newest in bit 0.
- Mid-operation reset: pulse RST_N low during ph = 2. All outputs return to reset values, and the sequence restarts at 1,0,0,0,0,1,…
- Differential build (QPSK_DIFF_EN): first three dibits 10, 00, 01 give q = 3, 3, 0, i.e. (I,Q) = (+127,−127), (+127,−127), (+127,+127).

Source files
------------

// File: rtl/qpsk_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_pkg
// Shared constants and helpers for the QPSK m-sequence test source:
//   - LFSR geometry and seed (5-bit maximal-length, 31-bit period)
//   - the two I/Q amplitude levels
//   - phase encoding of the fs/4 carrier and its per-phase select/sign tables
//   - small helpers for level mapping, negation and the differential Gray step
// No ports; imported by mseq_lfsr and qpsk_mseq_mod.
// -----------------------------------------------------------------------------
package qpsk_pkg;

  localparam int LFSR_W  = 5;
  localparam int SEQ_LEN = 31;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  localparam logic signed [7:0] AMP_POS = 8'sh7F;
  localparam logic signed [7:0] AMP_NEG = 8'sh81;

  // Carrier phase; one full carrier cycle spans one QPSK symbol.
  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_e;

  // Bit n of each table applies to phase n.
  // Phase sequence of the mixer output is I, -Q, -I, Q.
  localparam logic [3:0] CARRIER_SEL_Q = 4'b1010;
  localparam logic [3:0] CARRIER_NEG   = 4'b0110;

  // A set data bit maps to the negative level.
  function automatic logic signed [7:0] level_of(input logic b);
    return b ? AMP_NEG : AMP_POS;
  endfunction

  // Only +/-127 and 0 ever reach this, so the negation cannot overflow.
  function automatic logic signed [7:0] negate8(input logic signed [7:0] v);
    return -v;
  endfunction

  // Gray-coded dibit to quadrant increment: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_step(input logic [1:0] dibit);
    return {dibit[1], dibit[1] ^ dibit[0]};
  endfunction

endpackage

// File: rtl/mseq_lfsr.sv
// -----------------------------------------------------------------------------
// mseq_lfsr
// 5-bit Fibonacci right-shift LFSR, polynomial x^5 + x^3 + 1, seeded with
// LFSR_SEED on reset. Advances one step on every clock where en is high.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (loads the seed)
//   en     in   advance enable
//   bit_o  out  current sequence bit (state bit 0)
//   state  out  full register contents
// -----------------------------------------------------------------------------
module mseq_lfsr
  import qpsk_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              bit_o,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Feedback taps are bits 0 and 3; the new bit enters at the top.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[0] ^ state_q[3], state_q[LFSR_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bit_o = state_q[0];
  assign state = state_q;

endmodule

// File: rtl/qpsk_mseq_mod.sv
// -----------------------------------------------------------------------------
// qpsk_mseq_mod
// Self-contained QPSK test source: an m-sequence is paired into dibits,
// mapped to +/-127 I/Q levels and mixed onto an fs/4 carrier.
// One bit every 2 clocks, one symbol (= one carrier cycle) every 4 clocks.
// Ports:
//   CLK_50MHZ    in   board clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   out_fun      out  current m-sequence bit
//   dataI        out  signed in-phase level (+127 / -127, 0 after reset)
//   dataQ        out  signed quadrature level
//   data_origin  out  signed carrier sample, one register behind dataI/dataQ
//   buff_wr      out  last 31 emitted bits, newest in bit 0
// Build option:
//   QPSK_DIFF_EN  when defined, symbols are differentially encoded through a
//                 2-bit quadrant accumulator; otherwise direct mapping.
// -----------------------------------------------------------------------------
module qpsk_mseq_mod
  import qpsk_pkg::*;
(
  input  logic                     CLK_50MHZ,
  input  logic                     RST_N,
  output logic                     out_fun,
  output logic signed [7:0]        dataI,
  output logic signed [7:0]        dataQ,
  output logic signed [7:0]        data_origin,
  output logic [SEQ_LEN-1:0]       buff_wr
);

  phase_e                ph_q, ph_d;
  logic                  advance;
  logic                  lfsrBit;
  logic [LFSR_W-1:0]     lfsrState;
  logic                  unusedStateBits;

  logic                  b1_q, b1_d;
  logic signed [7:0]     dataI_q, dataI_d;
  logic signed [7:0]     dataQ_q, dataQ_d;
  logic signed [7:0]     origin_q, origin_d;
  logic signed [7:0]     carrierSrc;
  logic [SEQ_LEN-1:0]    buff_q, buff_d;
`ifdef QPSK_DIFF_EN
  logic [1:0]            quad_q, quad_d;
`endif

  // The sequence advances on the second and fourth clock of each symbol,
  // giving two bits per carrier cycle.
  assign advance = (ph_q == PH_1) || (ph_q == PH_3);

  mseq_lfsr u_lfsr (
    .clk   (CLK_50MHZ),
    .rst_n (RST_N),
    .en    (advance),
    .bit_o (lfsrBit),
    .state (lfsrState)
  );

  // Only the output bit is needed here; the rest of the state is observable
  // on the sub-module port for debug.
  assign unusedStateBits = ^lfsrState[LFSR_W-1:1];

  // Next-state: phase counter, dibit latch, mapper, history and mixer.
  always_comb begin
    ph_d     = phase_e'(ph_q + 2'd1);
    b1_d     = b1_q;
    dataI_d  = dataI_q;
    dataQ_d  = dataQ_q;
    buff_d   = buff_q;
`ifdef QPSK_DIFF_EN
    quad_d   = quad_q;
`endif

    if (advance) begin
      buff_d = {buff_q[SEQ_LEN-2:0], lfsrBit};
    end

    if (ph_q == PH_1) begin
      b1_d = lfsrBit;
    end

    // Second bit of the dibit is taken straight from the LFSR at this edge.
    if (ph_q == PH_3) begin
`ifdef QPSK_DIFF_EN
      quad_d  = quad_q + gray_step({b1_q, lfsrBit});
      dataI_d = level_of(quad_d[1] ^ quad_d[0]);
      dataQ_d = level_of(quad_d[1]);
`else
      dataI_d = level_of(b1_q);
      dataQ_d = level_of(lfsrBit);
`endif
    end

    // Mixer works on the registered levels, so it trails them by one stage.
    carrierSrc = CARRIER_SEL_Q[ph_q] ? dataQ_q : dataI_q;
    origin_d   = CARRIER_NEG[ph_q] ? negate8(carrierSrc) : carrierSrc;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      ph_q     <= PH_0;
      b1_q     <= 1'b0;
      dataI_q  <= '0;
      dataQ_q  <= '0;
      origin_q <= '0;
      buff_q   <= '0;
`ifdef QPSK_DIFF_EN
      quad_q   <= 2'd0;
`endif
    end else begin
      ph_q     <= ph_d;
      b1_q     <= b1_d;
      dataI_q  <= dataI_d;
      dataQ_q  <= dataQ_d;
      origin_q <= origin_d;
      buff_q   <= buff_d;
`ifdef QPSK_DIFF_EN
      quad_q   <= quad_d;
`endif
    end
  end

  assign out_fun     = lfsrBit;
  assign dataI       = dataI_q;
  assign dataQ       = dataQ_q;
  assign data_origin = origin_q;
  assign buff_wr     = buff_q;

endmodule

// File: tb/tb_qpsk_mseq_mod.sv
// -----------------------------------------------------------------------------
// tb_qpsk_mseq_mod
// Scoreboard bench for qpsk_mseq_mod. Expected values (hand-derived sequence
// and symbol levels) are queued tagged with the clock cycle they belong to;
// a monitor on the falling edge compares every entry whose cycle has come.
// Expectations follow QPSK_DIFF_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_qpsk_mseq_mod;

  logic              clk;
  logic              RST_N;
  logic              out_fun;
  logic signed [7:0] dataI;
  logic signed [7:0] dataQ;
  logic signed [7:0] data_origin;
  logic [30:0]       buff_wr;

  qpsk_mseq_mod dut (
    .CLK_50MHZ   (clk),
    .RST_N       (RST_N),
    .out_fun     (out_fun),
    .dataI       (dataI),
    .dataQ       (dataQ),
    .data_origin (data_origin),
    .buff_wr     (buff_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_OUT  = 0;
  localparam int K_I    = 1;
  localparam int K_Q    = 2;
  localparam int K_ORG  = 3;
  localparam int K_BUFF = 4;
  localparam int K_ONES = 5;

  // First three symbols are dibits 10, 00, 01.
`ifdef QPSK_DIFF_EN
  localparam logic [7:0] SYM1_I = 8'h7F, SYM1_Q = 8'h81;
  localparam logic [7:0] SYM2_I = 8'h7F, SYM2_Q = 8'h81;
  localparam logic [7:0] SYM3_I = 8'h7F, SYM3_Q = 8'h7F;
  localparam logic [7:0] ORG_P0 = 8'h7F, ORG_P1 = 8'h7F;
  localparam logic [7:0] ORG_P2 = 8'h81, ORG_P3 = 8'h81;
`else
  localparam logic [7:0] SYM1_I = 8'h81, SYM1_Q = 8'h7F;
  localparam logic [7:0] SYM2_I = 8'h7F, SYM2_Q = 8'h7F;
  localparam logic [7:0] SYM3_I = 8'h7F, SYM3_Q = 8'h81;
  localparam logic [7:0] ORG_P0 = 8'h81, ORG_P1 = 8'h81;
  localparam logic [7:0] ORG_P2 = 8'h7F, ORG_P3 = 8'h7F;
`endif

  // One full period of x^5+x^3+1 from seed 00001, hand-stepped.
  bit seqBits [31] = '{1,0,0,0,0, 1,0,1,0,1, 1,1,0,1,1, 0,0,0,1,1,
                       1,1,1,0,0, 1,1,0,1,0, 0};

  typedef struct {
    int          cyc;
    int          kind;
    logic [30:0] val;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   cycNum = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycNum <= cycNum + 1;

  task automatic expectAt(input int cyc, input int kind, input logic [30:0] val,
                          input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [30:0] act;
    act = '0;
    case (e.kind)
      K_OUT:   act[0]   = out_fun;
      K_I:     act[7:0] = dataI;
      K_Q:     act[7:0] = dataQ;
      K_ORG:   act[7:0] = data_origin;
      K_BUFF:  act      = buff_wr;
      default: act      = 31'($countones(buff_wr));
    endcase
    checks = checks + 1;
    if (act !== e.val) begin
      errors = errors + 1;
      $display("[TB] FAIL %s @cyc %0d: got %0h, want %0h", e.name, e.cyc, act, e.val);
    end
  endtask

  // Monitor: compare every entry due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = int'(expQ.size()) - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cycNum) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end else if (expQ[i].cyc < cycNum) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL %s @cyc %0d: check missed, now cyc %0d", expQ[i].name,
                 expQ[i].cyc, cycNum);
        expQ.delete(i);
      end
    end
  end

  task automatic applyStimulus(input logic rstLevel, input int edges);
    RST_N = rstLevel;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic expectResetState(input int cyc);
    expectAt(cyc, K_OUT,  31'd1, "reset out_fun");
    expectAt(cyc, K_BUFF, 31'd0, "reset buff_wr");
    expectAt(cyc, K_I,    31'd0, "reset dataI");
    expectAt(cyc, K_Q,    31'd0, "reset dataQ");
    expectAt(cyc, K_ORG,  31'd0, "reset data_origin");
  endtask

  // base is the cycle count at reset release; edge k lands on base+k.
  // out_fun carries bit j between advance edges 2j and 2j+2.
  task automatic expectRun(input int base, input int nBits, input bit full);
    logic [30:0] buffExp;
    for (int j = 0; j < nBits; j++) begin
      expectAt(base + 2*j + 1, K_OUT, 31'(seqBits[j % 31]), "out_fun bit");
    end
    expectAt(base + 4, K_I, {23'd0, SYM1_I}, "sym1 dataI");
    expectAt(base + 4, K_Q, {23'd0, SYM1_Q}, "sym1 dataQ");
    expectAt(base + 8, K_I, {23'd0, SYM2_I}, "sym2 dataI");
    expectAt(base + 8, K_Q, {23'd0, SYM2_Q}, "sym2 dataQ");
    if (full) begin
      expectAt(base + 12, K_I, {23'd0, SYM3_I}, "sym3 dataI");
      expectAt(base + 12, K_Q, {23'd0, SYM3_Q}, "sym3 dataQ");
      expectAt(base + 4, K_ORG, 31'd0,            "origin lag");
      expectAt(base + 5, K_ORG, {23'd0, ORG_P0}, "carrier ph0");
      expectAt(base + 6, K_ORG, {23'd0, ORG_P1}, "carrier ph1");
      expectAt(base + 7, K_ORG, {23'd0, ORG_P2}, "carrier ph2");
      expectAt(base + 8, K_ORG, {23'd0, ORG_P3}, "carrier ph3");
      for (int k = 0; k < 31; k++) begin
        buffExp[k] = seqBits[30 - k];
      end
      expectAt(base + 62, K_BUFF, buffExp, "buff_wr history");
      expectAt(base + 62, K_ONES, 31'd16,  "ones per period");
    end
  endtask

  initial begin
    int base;
    RST_N = 1'b0;
    applyStimulus(1'b0, 2);
    expectResetState(cycNum);
    applyStimulus(1'b0, 1);

    // First run: past one full period, including the wrap of the sequence.
    applyStimulus(1'b1, 0);
    base = cycNum;
    expectRun(base, 35, 1'b1);
    applyStimulus(1'b1, 70);

    // 70 edges after release the phase is 2: pulse reset mid-symbol.
    @(negedge clk);
    #1;
    RST_N = 1'b0;
    expectResetState(cycNum + 1);
    applyStimulus(1'b0, 2);

    applyStimulus(1'b1, 0);
    base = cycNum;
    expectRun(base, 6, 1'b0);
    applyStimulus(1'b1, 12);
    @(negedge clk);
    #1;

    while (expQ.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s @cyc %0d: never compared", expQ[0].name, expQ[0].cyc);
      void'(expQ.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
